// File: rtl/rle_pkg.sv
// Shared RLE code format and frame constants, used by both the RGB RLE encoder and decoder.
package rle_pkg;
    localparam int RLE_CODE_W  = 16;
    localparam int RLE_LEN_MSB = 15;
    localparam int RLE_LEN_LSB = 8;
    localparam int RLE_VAL_MSB = 7;
    localparam int RLE_VAL_LSB = 0;
    localparam int PIX_W       = 8;
    localparam int ADDR_W      = 16;
    localparam int LEN_W       = RLE_LEN_MSB - RLE_LEN_LSB + 1;
    localparam int NUM_CH      = 3;
    localparam int PIX_CNT_DEF = 21845;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [PIX_W-1:0] val;
    } rle_code_t;
endpackage

// File: rtl/rle_dec_chan.sv
// One colour channel of the RLE decoder: holds the current run and hands out its value.
module rle_dec_chan
    import rle_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RLE_CODE_W-1:0] code,
    input  logic                  vld,
    input  logic                  done,
    input  logic                  dec,
    output logic                  rdy,
    output logic                  nonempty,
    output logic [PIX_W-1:0]      val
);
    rle_code_t        code_s;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [PIX_W-1:0] val_q, val_d;

    assign code_s   = rle_code_t'(code);
    assign rdy      = !done && (rem_q == '0);
    assign nonempty = (rem_q != '0);
    assign val      = val_q;

    // Accept and decrement are exclusive: accept needs rem==0, decrement needs rem>0.
    always_comb begin
        rem_d = rem_q;
        val_d = val_q;
        if (vld && rdy) begin
            rem_d = code_s.len;
            val_d = code_s.val;
        end else if (dec) begin
            rem_d = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            val_q <= '0;
        end else begin
            rem_q <= rem_d;
            val_q <= val_d;
        end
    end
endmodule

// File: rtl/rle_dec.sv
// RGB RLE decoder: expands three per-channel run streams into a paced pixel stream with strobe E.
module rle_dec
    import rle_pkg::*;
#(
    parameter int HOLD_CLK = 1,
    parameter int PIX_CNT  = PIX_CNT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RLE_CODE_W-1:0] R_code,
    input  logic [RLE_CODE_W-1:0] G_code,
    input  logic [RLE_CODE_W-1:0] B_code,
    input  logic                  R_vld,
    input  logic                  G_vld,
    input  logic                  B_vld,
    output logic                  R_rdy,
    output logic                  G_rdy,
    output logic                  B_rdy,
    output logic                  E,
    output logic [PIX_W-1:0]      R,
    output logic [PIX_W-1:0]      G,
    output logic [PIX_W-1:0]      B,
    output logic                  done
);
    localparam int                HOLD_W   = $clog2(HOLD_CLK) + 1;
    localparam logic [HOLD_W-1:0] HOLD_RLD = HOLD_W'(HOLD_CLK - 1);
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIX_CNT - 1);

    logic [NUM_CH-1:0][RLE_CODE_W-1:0] code;
    logic [NUM_CH-1:0]                 vld, rdy, nonempty;
    logic [NUM_CH-1:0][PIX_W-1:0]      val;
    logic                              emit;

    logic [HOLD_W-1:0]            hold_q, hold_d;
    logic [ADDR_W-1:0]            pix_q, pix_d;
    logic                         done_q, done_d;
    logic                         e_q, e_d;
    logic [NUM_CH-1:0][PIX_W-1:0] rgb_q, rgb_d;

    // Lane 0 = R, 1 = G, 2 = B.
    assign code = {B_code, G_code, R_code};
    assign vld  = {B_vld, G_vld, R_vld};

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
            rle_dec_chan u_chan (
                .clk      (clk),
                .rst      (rst),
                .code     (code[i]),
                .vld      (vld[i]),
                .done     (done_q),
                .dec      (emit),
                .rdy      (rdy[i]),
                .nonempty (nonempty[i]),
                .val      (val[i])
            );
        end
    endgenerate

    assign emit = (&nonempty) && (hold_q == '0) && !done_q;

    always_comb begin
        hold_d = hold_q;
        pix_d  = pix_q;
        done_d = done_q;
        e_d    = 1'b0;
        rgb_d  = rgb_q;
        if (emit) begin
            e_d    = 1'b1;
            rgb_d  = val;
            pix_d  = pix_q + 1'b1;
            hold_d = HOLD_RLD;
            // done rises together with the final strobe and then blocks all counting.
            if (pix_q == PIX_LAST) done_d = 1'b1;
        end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            pix_q  <= '0;
            done_q <= 1'b0;
            e_q    <= 1'b0;
            rgb_q  <= '0;
        end else begin
            hold_q <= hold_d;
            pix_q  <= pix_d;
            done_q <= done_d;
            e_q    <= e_d;
            rgb_q  <= rgb_d;
        end
    end

    assign R_rdy = rdy[0];
    assign G_rdy = rdy[1];
    assign B_rdy = rdy[2];
    assign E     = e_q;
    assign R     = rgb_q[0];
    assign G     = rgb_q[1];
    assign B     = rgb_q[2];
    assign done  = done_q;
endmodule
